// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider: ALU op codes used by the
// E stage, iteration count and the divider FSM state type.
package div_unit_pkg;

  localparam logic [7:0] EXE_MFHI_OP  = 8'b00010000;
  localparam logic [7:0] EXE_MULT_OP  = 8'b00011000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b00011001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b00011010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b00011011;

  localparam int unsigned DIV_ITER = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_BUSY = 2'b01,
    DIV_DONE = 2'b10
  } div_state_e;

  function automatic logic is_div_op(input logic [7:0] op);
    return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
  endfunction

endpackage

// File: rtl/div_unit_if.sv
// E-stage divider bus: decoded op, operands and the stall/result return path.
interface div_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic [7:0]       alucontrol;
  logic             en_i;
  logic             flush_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             stall_o;
  logic             done_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;

  modport master (
    output alucontrol, en_i, flush_i, a_i, b_i,
    input  stall_o, done_o, hi_o, lo_o
  );

  modport slave (
    input  alucontrol, en_i, flush_i, a_i, b_i,
    output stall_o, done_o, hi_o, lo_o
  );
endinterface

// File: rtl/div_unit_abs.sv
// Conditional two's-complement negate, used for operand magnitudes and the
// final quotient/remainder sign fix.
module div_abs #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] val_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] res_o
);

  always_comb begin
    res_o = val_i;
    if (neg_i) res_o = ~val_i + WIDTH'(1);
  end

endmodule

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU: stalls the pipeline for the
// WIDTH iterations and pulses done_o with quotient on lo_o, remainder on hi_o.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_ITER,
  parameter int unsigned CNT_W = 6
) (
  input logic       clk,
  input logic       rst,
  div_unit_if.slave bus
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             neg_a_q, neg_a_d;
  logic             neg_b_q, neg_b_d;
  logic             dvz_q, dvz_d;

  logic             start;
  logic             signed_op;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   rem_sh;
  logic             rem_ge;
  logic [WIDTH-1:0] rem_nx, quot_nx;
  logic [WIDTH-1:0] q_fix, r_fix;
  logic             last_iter;

  assign signed_op = (bus.alucontrol == EXE_DIV_OP);
  assign start     = bus.en_i & ~bus.flush_i & is_div_op(bus.alucontrol);
  assign a_neg     = signed_op & bus.a_i[WIDTH-1];
  assign b_neg     = signed_op & bus.b_i[WIDTH-1];

  div_abs #(.WIDTH(WIDTH)) u_abs_a (.val_i(bus.a_i), .neg_i(a_neg), .res_o(a_mag));
  div_abs #(.WIDTH(WIDTH)) u_abs_b (.val_i(bus.b_i), .neg_i(b_neg), .res_o(b_mag));

  // The shifted partial remainder needs WIDTH+1 bits for the compare, but the
  // difference is always below the divisor, so WIDTH-bit subtraction suffices.
  assign rem_sh    = {rem_q, quot_q[WIDTH-1]};
  assign rem_ge    = rem_sh >= {1'b0, dvs_q};
  assign rem_nx    = rem_ge ? (rem_sh[WIDTH-1:0] - dvs_q) : rem_sh[WIDTH-1:0];
  assign quot_nx   = {quot_q[WIDTH-2:0], rem_ge};
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

  div_abs #(.WIDTH(WIDTH)) u_fix_q (.val_i(quot_nx), .neg_i(neg_a_q ^ neg_b_q), .res_o(q_fix));
  div_abs #(.WIDTH(WIDTH)) u_fix_r (.val_i(rem_nx),  .neg_i(neg_a_q),           .res_o(r_fix));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quot_d  = quot_q;
    dvs_d   = dvs_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    dvz_d   = dvz_q;

    if (bus.flush_i) begin
      state_d = DIV_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        DIV_IDLE: begin
          if (start) begin
            rem_d   = '0;
            quot_d  = a_mag;
            dvs_d   = b_mag;
            neg_a_d = a_neg;
            neg_b_d = b_neg;
            dvz_d   = (bus.b_i == '0);
            cnt_d   = '0;
            state_d = DIV_BUSY;
          end
        end
        DIV_BUSY: begin
          rem_d  = rem_nx;
          quot_d = quot_nx;
          cnt_d  = cnt_q + CNT_W'(1);
          if (last_iter) begin
            state_d = DIV_DONE;
            // With a zero divisor the remainder ends as |a|, so the sign fix
            // restores the raw dividend exactly.
            lo_d    = dvz_q ? '1 : q_fix;
            hi_d    = r_fix;
          end
        end
        DIV_DONE: state_d = DIV_IDLE;
        default:  state_d = DIV_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quot_q  <= '0;
      dvs_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      dvz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quot_q  <= quot_d;
      dvs_q   <= dvs_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      dvz_q   <= dvz_d;
    end
  end

  assign bus.stall_o = ((state_q == DIV_IDLE) & start) | (state_q == DIV_BUSY);
  assign bus.done_o  = (state_q == DIV_DONE);
  assign bus.hi_o    = hi_q;
  assign bus.lo_o    = lo_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed and random DIV/DIVU traffic against a plain-arithmetic reference,
// including latency, flush, mid-operation reset and non-div op codes.
module tb_div_unit;
  import div_unit_pkg::*;

  logic clk;
  logic rst;
  int   passed;
  int   total;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  div_unit_if #(.WIDTH(32)) bus ();

  div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  // Reference: divide-by-zero gives all-ones / dividend; otherwise truncating
  // division done in 64-bit so the most-negative / -1 case cannot overflow.
  function automatic void ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
    longint sa, sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  task automatic do_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                        input bit hold_en, input string tag);
    logic [31:0] eq, er;
    int cyc;
    bit stall_ok;
    ref_div(sgn, a, b, eq, er);
    @(posedge clk); #1;
    bus.en_i       = 1'b1;
    bus.flush_i    = 1'b0;
    bus.alucontrol = sgn ? EXE_DIV_OP : EXE_DIVU_OP;
    bus.a_i        = a;
    bus.b_i        = b;
    @(negedge clk);
    chk({tag, " stall c0"}, 32'(bus.stall_o), 32'd1);
    cyc = 0;
    stall_ok = 1'b1;
    while (cyc < 40) begin
      @(posedge clk); #1;
      if (!hold_en) begin
        bus.en_i       = 1'($urandom_range(0, 1));
        bus.alucontrol = EXE_MULT_OP;
        bus.a_i        = $urandom();
        bus.b_i        = $urandom();
      end
      cyc++;
      @(negedge clk);
      if (bus.done_o) break;
      if (!bus.stall_o) stall_ok = 1'b0;
    end
    chk({tag, " latency"}, 32'(cyc), 32'd33);
    chk({tag, " stall busy"}, 32'(stall_ok), 32'd1);
    chk({tag, " stall done"}, 32'(bus.stall_o), 32'd0);
    chk({tag, " lo"}, bus.lo_o, eq);
    chk({tag, " hi"}, bus.hi_o, er);
    @(posedge clk); #1;
    bus.en_i       = 1'b0;
    bus.alucontrol = EXE_MULT_OP;
    @(negedge clk);
    chk({tag, " done 1 pulse"}, 32'(bus.done_o), 32'd0);
    chk({tag, " no restart"}, 32'(bus.stall_o), 32'd0);
    chk({tag, " lo hold"}, bus.lo_o, eq);
    chk({tag, " hi hold"}, bus.hi_o, er);
    exp_lo = eq;
    exp_hi = er;
  endtask

  initial begin
    bit          any_done;
    bit          sgn;
    logic [31:0] ra, rb;
    logic [7:0]  other_ops [4];

    passed = 0;
    total  = 0;
    exp_hi = '0;
    exp_lo = '0;
    other_ops[0] = EXE_MULT_OP;
    other_ops[1] = EXE_MULTU_OP;
    other_ops[2] = EXE_MFHI_OP;
    other_ops[3] = 8'h00;

    rst            = 1'b1;
    bus.en_i       = 1'b0;
    bus.flush_i    = 1'b0;
    bus.alucontrol = 8'h00;
    bus.a_i        = '0;
    bus.b_i        = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset stall", 32'(bus.stall_o), 32'd0);
    chk("reset done", 32'(bus.done_o), 32'd0);
    chk("reset hi", bus.hi_o, 32'd0);
    chk("reset lo", bus.lo_o, 32'd0);

    do_div(1'b1, 32'd7, 32'd2, 1'b1, "div 7/2");
    do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, "div -7/2");
    do_div(1'b0, 32'hFFFF_FFF9, 32'd2, 1'b1, "divu -7/2");
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div min/-1");
    do_div(1'b0, 32'hFFFF_FFFF, 32'h10, 1'b1, "divu max/16");
    do_div(1'b1, 32'h1234_5678, 32'd0, 1'b0, "div by zero");
    do_div(1'b1, 32'hFFFF_FF00, 32'd0, 1'b1, "div neg by zero");

    // Non-div codes never start an operation.
    foreach (other_ops[i]) begin
      @(posedge clk); #1;
      bus.en_i       = 1'b1;
      bus.alucontrol = other_ops[i];
      bus.a_i        = $urandom();
      bus.b_i        = $urandom();
      @(negedge clk);
      chk("other op stall", 32'(bus.stall_o), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("other op done", 32'(bus.done_o), 32'd0);
      chk("other op lo hold", bus.lo_o, exp_lo);
    end

    // Flush coincident with a start suppresses it.
    @(posedge clk); #1;
    bus.alucontrol = EXE_DIV_OP;
    bus.flush_i    = 1'b1;
    @(negedge clk);
    chk("flush+start stall", 32'(bus.stall_o), 32'd0);
    @(posedge clk); #1;
    bus.flush_i = 1'b0;
    bus.en_i    = 1'b0;
    @(negedge clk);
    chk("flush+start idle", 32'(bus.stall_o), 32'd0);

    // Flush at cycle 10 of a running divide, then restart at cycle 12.
    @(posedge clk); #1;
    bus.en_i       = 1'b1;
    bus.alucontrol = EXE_DIV_OP;
    bus.a_i        = 32'd1000;
    bus.b_i        = 32'd7;
    any_done = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      bus.en_i = 1'b0;
      @(negedge clk);
      if (bus.done_o) any_done = 1'b1;
    end
    @(posedge clk); #1;
    bus.flush_i = 1'b1;
    @(negedge clk);
    chk("flush c10 stall", 32'(bus.stall_o), 32'd1);
    if (bus.done_o) any_done = 1'b1;
    @(posedge clk); #1;
    bus.flush_i = 1'b0;
    @(negedge clk);
    if (bus.done_o) any_done = 1'b1;
    chk("flush no done", 32'(any_done), 32'd0);
    chk("flush c11 stall", 32'(bus.stall_o), 32'd0);
    chk("flush hi hold", bus.hi_o, exp_hi);
    chk("flush lo hold", bus.lo_o, exp_lo);
    do_div(1'b1, 32'hFFFF_FC18, 32'd7, 1'b0, "after flush");

    // Reset at cycle 20 of a running divide.
    @(posedge clk); #1;
    bus.en_i       = 1'b1;
    bus.alucontrol = EXE_DIVU_OP;
    bus.a_i        = 32'hDEAD_BEEF;
    bus.b_i        = 32'd3;
    any_done = 1'b0;
    for (int k = 1; k <= 19; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (bus.done_o) any_done = 1'b1;
    end
    @(posedge clk); #1;
    rst      = 1'b1;
    bus.en_i = 1'b0;
    @(negedge clk);
    if (bus.done_o) any_done = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    if (bus.done_o) any_done = 1'b1;
    chk("rst no done", 32'(any_done), 32'd0);
    chk("rst stall", 32'(bus.stall_o), 32'd0);
    chk("rst hi", bus.hi_o, 32'd0);
    chk("rst lo", bus.lo_o, 32'd0);
    exp_hi = '0;
    exp_lo = '0;

    for (int n = 0; n < 12; n++) begin
      sgn = 1'($urandom_range(0, 1));
      ra  = $urandom();
      case ($urandom_range(0, 4))
        0:       rb = 32'($urandom_range(1, 15));
        1:       rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 7));
        2:       rb = '0;
        default: rb = $urandom();
      endcase
      do_div(sgn, ra, rb, 1'($urandom_range(0, 1)), "random");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
